// File: rtl/hmi_arbiter.sv
// HMI bus arbiter: replays queued keypad codes as frame-timed press/release
// pulses over live input, and applies per-controller autofire to trigger 1.
package hmi_pkg;
    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
        logic t1;
        logic t2;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      c1;
        ctrl_t      c2;
        logic [9:0] num;
        logic       cl;
        logic       en;
        logic       pause;
    } hmi_t;
endpackage

module hmi_arbiter
    import hmi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned HOLD_FRAMES = 3,
    parameter int unsigned GAP_FRAMES  = 3,
    parameter int unsigned AF_PERIOD   = 4
) (
    input  logic       CLK_SYS,
    input  logic       RST_N,
    input  logic       VBL,
    input  hmi_t       HMI_IN,
    input  logic [1:0] AF_EN,
    input  logic       INJ_VALID,
    input  logic [3:0] INJ_KEY,
    output logic       INJ_READY,
    output logic       INJ_BUSY,
    output hmi_t       HMI
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned CNT_MAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned AF_W    = $clog2(AF_PERIOD + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_RELEASE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        key_q, key_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AF_W-1:0]   af_cnt_q, af_cnt_d;
    logic              phase_q, phase_d;
    logic              vbl_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [3:0]        mem_q [FIFO_DEPTH];
    hmi_t              hmi_q, hmi_d;
    logic              busy_q, busy_d;

    logic       tick, full, push, pop;
    logic [3:0] head;

    assign tick      = VBL & ~vbl_q;
    assign full      = (fill_q == FILL_W'(FIFO_DEPTH));
    assign push      = INJ_VALID & ~full;
    assign head      = mem_q[rd_ptr_q];
    assign INJ_READY = ~full;
    assign INJ_BUSY  = busy_q;
    assign HMI       = hmi_q;

    // Sequencer next-state; IDLE pops one entry per cycle, skipping reserved codes
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_q != '0) begin
                    pop = 1'b1;
                    if (head < 4'd13) begin
                        key_d   = head;
                        cnt_d   = '0;
                        state_d = ST_PRESS;
                    end
                end
            end
            ST_PRESS: begin
                if (tick) begin
                    if (cnt_q + CNT_W'(1) == CNT_W'(HOLD_FRAMES)) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (cnt_q + CNT_W'(1) == CNT_W'(GAP_FRAMES)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers and fill count; depth is a power of two so pointers wrap freely
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Free-running autofire phase
    always_comb begin
        af_cnt_d = af_cnt_q;
        phase_d  = phase_q;
        if (tick) begin
            if (af_cnt_q == AF_W'(AF_PERIOD - 1)) begin
                af_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                af_cnt_d = af_cnt_q + AF_W'(1);
            end
        end
    end

    // Output mux uses next state so a state change lands on HMI in the same edge
    always_comb begin
        hmi_d       = HMI_IN;
        hmi_d.c1.t1 = HMI_IN.c1.t1 & (~AF_EN[0] | phase_d);
        hmi_d.c2.t1 = HMI_IN.c2.t1 & (~AF_EN[1] | phase_d);
        if (state_d != ST_IDLE) begin
            hmi_d.num   = '0;
            hmi_d.cl    = 1'b0;
            hmi_d.en    = 1'b0;
            hmi_d.pause = 1'b0;
            if (state_d == ST_PRESS) begin
                if (key_d < 4'd10)       hmi_d.num[key_d] = 1'b1;
                else if (key_d == 4'd10) hmi_d.cl    = 1'b1;
                else if (key_d == 4'd11) hmi_d.en    = 1'b1;
                else if (key_d == 4'd12) hmi_d.pause = 1'b1;
            end
        end
        busy_d = (fill_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_SYS) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            cnt_q    <= '0;
            af_cnt_q <= '0;
            phase_q  <= 1'b0;
            vbl_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            hmi_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            af_cnt_q <= af_cnt_d;
            phase_q  <= phase_d;
            vbl_q    <= VBL;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            hmi_q    <= hmi_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge CLK_SYS) begin
        if (push) mem_q[wr_ptr_q] <= INJ_KEY;
    end
endmodule
